insn_fetch: RTL and testbench
=============================

INSN_FETCH -- requirements
Module: insn_fetch

Interface
REQ-001 Parameter: INSN_WIDTH, 16, instruction width in bits.
REQ-002 Parameter: DATA_WIDTH, 16, address/PC width in bits.
REQ-003 Parameter: START_ADDRESS, 16'h0, PC value after reset.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: imem_req  output  1  instruction memory read request.
REQ-007 Port: imem_addr  output  DATA_WIDTH  word address of the requested instruction.
REQ-008 Port: imem_ack  input  1  memory response valid; qualifies imem_rdata.
REQ-009 Port: imem_rdata  input  INSN_WIDTH  instruction word returned by memory.
REQ-010 Port: out_valid  output  1  instruction available to the decode stage.
REQ-011 Port: out_insn  output  INSN_WIDTH  buffered instruction word.
REQ-012 Port: out_pc  output  DATA_WIDTH  address out_insn was fetched from.
REQ-013 Port: out_ready  input  1  decode accepts out_insn this cycle.
REQ-014 Port: redirect_valid  input  1  branch/jump taken; discard the current fetch.
REQ-015 Port: redirect_target  input  DATA_WIDTH  new PC on redirect.
REQ-016 Port: halted  output  1  HLT instruction (16'h0) consumed; fetch stopped.

Function
REQ-017 States SHALL be FETCH, FLUSH, VALID and HALT, with a single DATA_WIDTH pc register.
REQ-018 FETCH: imem_req=1, imem_addr=pc; imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-019 FETCH with imem_ack and no redirect: out_insn<=imem_rdata, out_pc<=pc, go to VALID.
REQ-020 VALID: out_valid=1, imem_req=0; out_insn and out_pc SHALL be held until the transfer.
REQ-021 Transfer (out_valid && out_ready) of a non-HLT word: pc<=pc+1 (wraps 16'hFFFF->16'h0000), go to FETCH.
REQ-022 Transfer of out_insn==16'h0 (HLT): go to HALT, pc unchanged.
REQ-023 HALT: halted=1, out_valid=0, imem_req=0; only reset SHALL exit HALT.
REQ-024 Redirect in VALID, with or without out_ready: the buffered word SHALL be dropped, pc<=redirect_target, go to FETCH.
REQ-025 Redirect in FETCH with imem_ack in the same cycle: the response SHALL be dropped, pc<=redirect_target, go to FETCH.
REQ-026 Redirect in FETCH without imem_ack: pc<=redirect_target, go to FLUSH.
REQ-027 FLUSH: imem_req=1 and imem_addr=old in-flight address until imem_ack; that response SHALL be discarded; then go to FETCH.
REQ-028 FLUSH: imem_addr SHALL be driven from a latched copy of the in-flight address, not from pc.
REQ-029 Redirect during FLUSH: pc<=latest redirect_target, stay in FLUSH (or go to FETCH if imem_ack is also set).
REQ-030 Redirect in HALT SHALL be ignored.
REQ-031 Latency: imem_ack in cycle N SHALL give out_valid=1 in cycle N+1; a transfer in cycle M SHALL give imem_req=1 in cycle M+1.
REQ-032 Throughput SHALL be at most one instruction per two cycles; no internal bypass.
REQ-033 imem_ack outside FETCH/FLUSH SHALL be ignored.

Reset
REQ-034 reset=1 at a clock edge SHALL force state=FETCH, pc=START_ADDRESS, out_valid=0, out_insn=16'h0, out_pc=16'h0, halted=0.
REQ-035 Reset SHALL override all other inputs in the same cycle, including mid-FLUSH and HALT.
REQ-036 Reset mid-FLUSH SHALL abandon the discard obligation; the memory model SHALL be reset alongside this block.
REQ-037 imem_req SHALL be 0 during any cycle with reset=1.
REQ-038 imem_req SHALL be 1 with imem_addr=START_ADDRESS in the first cycle after reset deasserts.

Verification
REQ-039 Sequential fetch: 1-cycle-ack memory holding 16'h1 (NOP) at 0..3, out_ready=1 -> out_pc 0,1,2,3 on every other cycle, out_insn=16'h1.
REQ-040 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_insn/out_pc stable, imem_req=0; release -> next imem_addr=pc+1.
REQ-041 Redirect in flight: 3-cycle memory, redirect to 16'h0040 one cycle after the request -> old response discarded, next accepted fetch at 16'h0040, no stale out_valid.
REQ-042 Simultaneous redirect and imem_ack in FETCH -> response dropped, imem_addr=redirect_target next cycle.
REQ-043 Halt: 16'h0 at address 5 -> word transferred with out_pc=5, halted=1 next cycle, redirect and imem_ack ignored; reset -> imem_addr=16'h0000.
REQ-044 Wrap: redirect to 16'hFFFF, transfer NOP -> next imem_addr=16'h0000.

Source files
------------

// File: rtl/insn_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode-side
// handshake, redirect input and halt status.
interface insn_fetch_if #(
  parameter int INSN_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [INSN_WIDTH-1:0] imem_rdata;
  logic                  out_valid;
  logic [INSN_WIDTH-1:0] out_insn;
  logic [DATA_WIDTH-1:0] out_pc;
  logic                  out_ready;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  halted;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, out_valid, out_insn, out_pc, halted,
    input  imem_ack, imem_rdata, out_ready, redirect_valid, redirect_target
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_req, imem_addr, out_valid, out_insn, out_pc, halted,
    output imem_ack, imem_rdata, out_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/insn_fetch.sv
// Single-entry instruction fetch unit. Requests one word at pc, buffers the
// response for decode, and follows redirects. A redirect while a memory
// request is outstanding leaves that request in flight (FLUSH) so the memory
// handshake stays legal; its response is thrown away. Fetching a 16'h0 word
// (HLT) parks the unit until reset.
module insn_fetch #(
  parameter int                    INSN_WIDTH    = 16,
  parameter int                    DATA_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0] START_ADDRESS = '0
) (
  input  logic          clk,
  input  logic          reset,
  insn_fetch_if.master  bus
);

  typedef enum logic [1:0] {FETCH, FLUSH, VALID, HALT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] flush_addr_q;
  logic [DATA_WIDTH-1:0] out_pc_q;
  logic [INSN_WIDTH-1:0] out_insn_q;
  logic                  capture;
  logic                  latch_flush;

  // Next-state, next-pc and buffer-load decisions
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    capture     = 1'b0;
    latch_flush = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_target;
          if (!bus.imem_ack) begin
            // Request still outstanding: keep presenting it until it returns.
            state_d     = FLUSH;
            latch_flush = 1'b1;
          end
        end else if (bus.imem_ack) begin
          capture = 1'b1;
          state_d = VALID;
        end
      end
      FLUSH: begin
        if (bus.redirect_valid) pc_d = bus.redirect_target;
        if (bus.imem_ack) state_d = FETCH;
      end
      VALID: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_target;
          state_d = FETCH;
        end else if (bus.out_ready) begin
          if (out_insn_q == '0) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_q + DATA_WIDTH'(1);
            state_d = FETCH;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // State, pc and decode buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= START_ADDRESS;
      out_insn_q <= '0;
      out_pc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (capture) begin
        out_insn_q <= bus.imem_rdata;
        out_pc_q   <= pc_q;
      end
    end
  end

  // Address of the abandoned request, replayed on imem_addr while flushing
  always_ff @(posedge clk) begin
    if (latch_flush) flush_addr_q <= pc_q;
  end

  assign bus.imem_req  = !reset && ((state_q == FETCH) || (state_q == FLUSH));
  assign bus.imem_addr = (state_q == FLUSH) ? flush_addr_q : pc_q;
  assign bus.out_valid = (state_q == VALID);
  assign bus.out_insn  = out_insn_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.halted    = (state_q == HALT);

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch unit.
module tb_insn_fetch;
  localparam int IW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  insn_fetch_if #(.INSN_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  insn_fetch #(.INSN_WIDTH(IW), .DATA_WIDTH(DW), .START_ADDRESS(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory contents: default word is 16'hA000 | addr[11:0] (never HLT)
  logic [15:0] mem_ovr [logic [15:0]];
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {4'hA, a[11:0]};
  endfunction

  int lat       = 1;
  int wait_cnt  = 0;
  bit force_ack = 1'b0;

  // Transaction-level model: buffer occupancy, pending discard, halt
  bit          m_halted, m_full, m_discard;
  logic [15:0] m_pc, m_daddr, m_word, m_wpc;

  // Drive one cycle's inputs on the falling edge; memory answers after lat
  // cycles of continuous request, and is reset alongside the DUT.
  task automatic cycle(input bit rst_in, input bit rdy, input bit redir, input logic [15:0] tgt);
    @(negedge clk);
    reset               = rst_in;
    bus.out_ready       = rdy;
    bus.redirect_valid  = redir;
    bus.redirect_target = tgt;
    #1;
    if (bus.imem_req && !rst_in) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        wait_cnt       = 0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'($urandom);
      end
    end else begin
      wait_cnt       = 0;
      bus.imem_ack   = force_ack && !rst_in;
      bus.imem_rdata = 16'($urandom);
    end
    #1;
  endtask

  // Clock edge plus model update from the inputs presented this cycle
  task automatic advance();
    bit          r, rd, rv, ak;
    logic [15:0] tg;
    r = reset; rd = bus.out_ready; rv = bus.redirect_valid; tg = bus.redirect_target; ak = bus.imem_ack;
    @(posedge clk);
    if (r) begin
      m_halted = 0; m_full = 0; m_discard = 0; m_pc = 16'h0; m_word = 16'h0; m_wpc = 16'h0;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_full) begin
      if (rv) begin
        m_full = 0; m_pc = tg;
      end else if (rd) begin
        m_full = 0;
        if (m_word == 16'h0) m_halted = 1;
        else m_pc = m_pc + 16'h1;
      end
    end else if (m_discard) begin
      if (rv) m_pc = tg;
      if (ak) m_discard = 0;
    end else if (rv) begin
      if (!ak) begin
        m_discard = 1; m_daddr = m_pc;
      end
      m_pc = tg;
    end else if (ak) begin
      m_full = 1; m_word = mem_word(m_pc); m_wpc = m_pc;
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    advance();
  endtask

  task automatic test_reset();
    lat = 1; force_ack = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 16'h1234);
      n_checks++;
      if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
      if (i > 0) begin
        n_checks++;
        if ({bus.out_valid, bus.halted} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: valid/halted got %b want 00", {bus.out_valid, bus.halted}); end
        n_checks++;
        if ({bus.out_insn, bus.out_pc} !== 32'h0) begin n_fail++; $display("FAIL reset_regs: insn/pc got %h want 00000000", {bus.out_insn, bus.out_pc}); end
      end
      advance();
    end
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL reset_first_req: req/addr got %b/%h want 1/0000", bus.imem_req, bus.imem_addr); end
    advance();
  endtask

  task automatic test_sequential();
    for (int a = 0; a < 4; a++) mem_ovr[16'(a)] = 16'h0001;
    lat = 1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      n_checks++;
      if (k % 2 == 1) begin
        if ({bus.out_valid, bus.imem_req, bus.out_pc, bus.out_insn} !== {1'b1, 1'b0, 16'((k - 1) / 2), 16'h0001}) begin
          n_fail++; $display("FAIL seq_out k=%0d: valid/req/pc/insn got %b/%b/%h/%h want 1/0/%h/0001", k, bus.out_valid, bus.imem_req, bus.out_pc, bus.out_insn, 16'((k - 1) / 2));
        end
      end else begin
        if ({bus.out_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 16'(k / 2)}) begin
          n_fail++; $display("FAIL seq_req k=%0d: valid/req/addr got %b/%b/%h want 0/1/%h", k, bus.out_valid, bus.imem_req, bus.imem_addr, 16'(k / 2));
        end
      end
      advance();
    end
    mem_ovr.delete();
  endtask

  task automatic test_backpressure();
    lat = 1;
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    advance();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      n_checks++;
      if ({bus.out_valid, bus.imem_req, bus.out_pc, bus.out_insn} !== {1'b1, 1'b0, 16'h0000, 16'hA000}) begin
        n_fail++; $display("FAIL bp_hold i=%0d: valid/req/pc/insn got %b/%b/%h/%h want 1/0/0000/a000", i, bus.out_valid, bus.imem_req, bus.out_pc, bus.out_insn);
      end
      advance();
    end
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    advance();
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr, bus.out_valid} !== {1'b1, 16'h0001, 1'b0}) begin
      n_fail++; $display("FAIL bp_release: req/addr/valid got %b/%h/%b want 1/0001/0", bus.imem_req, bus.imem_addr, bus.out_valid);
    end
    advance();
  endtask

  task automatic test_redirect_flight();
    lat = 3;
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    advance();
    cycle(1'b0, 1'b1, 1'b1, 16'h0040);
    advance();
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr, bus.out_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL flush_addr: req/addr/valid got %b/%h/%b want 1/0000/0", bus.imem_req, bus.imem_addr, bus.out_valid);
    end
    advance();
    for (int c = 3; c < 6; c++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      n_checks++;
      if ({bus.imem_req, bus.imem_addr, bus.out_valid} !== {1'b1, 16'h0040, 1'b0}) begin
        n_fail++; $display("FAIL redir_fetch c=%0d: req/addr/valid got %b/%h/%b want 1/0040/0", c, bus.imem_req, bus.imem_addr, bus.out_valid);
      end
      advance();
    end
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_insn} !== {1'b1, 16'h0040, 16'hA040}) begin
      n_fail++; $display("FAIL redir_out: valid/pc/insn got %b/%h/%h want 1/0040/a040", bus.out_valid, bus.out_pc, bus.out_insn);
    end
    advance();
  endtask

  task automatic test_redirect_ack();
    lat = 1;
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 16'h1234);
    advance();
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr, bus.out_valid} !== {1'b1, 16'h1234, 1'b0}) begin
      n_fail++; $display("FAIL redir_ack: req/addr/valid got %b/%h/%b want 1/1234/0", bus.imem_req, bus.imem_addr, bus.out_valid);
    end
    advance();
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_insn} !== {1'b1, 16'h1234, 16'hA234}) begin
      n_fail++; $display("FAIL redir_ack_out: valid/pc/insn got %b/%h/%h want 1/1234/a234", bus.out_valid, bus.out_pc, bus.out_insn);
    end
    advance();
  endtask

  task automatic test_halt();
    lat = 1;
    mem_ovr[16'h0005] = 16'h0000;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      if (k == 11) begin
        n_checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_insn} !== {1'b1, 16'h0005, 16'h0000}) begin
          n_fail++; $display("FAIL halt_word: valid/pc/insn got %b/%h/%h want 1/0005/0000", bus.out_valid, bus.out_pc, bus.out_insn);
        end
      end
      advance();
    end
    force_ack = 1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 16'h0040);
      n_checks++;
      if ({bus.halted, bus.out_valid, bus.imem_req} !== 3'b100) begin
        n_fail++; $display("FAIL halt_hold i=%0d: halted/valid/req got %b want 100", i, {bus.halted, bus.out_valid, bus.imem_req});
      end
      advance();
    end
    force_ack = 0;
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    n_checks++;
    if ({bus.halted, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL halt_reset: halted/req/addr got %b/%b/%h want 0/1/0000", bus.halted, bus.imem_req, bus.imem_addr);
    end
    advance();
    mem_ovr.delete();
  endtask

  task automatic test_wrap();
    lat = 1;
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 16'hFFFF);
    advance();
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    advance();
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_insn} !== {1'b1, 16'hFFFF, 16'hAFFF}) begin
      n_fail++; $display("FAIL wrap_out: valid/pc/insn got %b/%h/%h want 1/ffff/afff", bus.out_valid, bus.out_pc, bus.out_insn);
    end
    advance();
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL wrap_addr: req/addr got %b/%h want 1/0000", bus.imem_req, bus.imem_addr);
    end
    advance();
  endtask

  task automatic test_random();
    bit          r, rd, rv;
    logic [15:0] tg;
    mem_ovr[16'h0200] = 16'h0000;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) lat = 1 + int'($urandom_range(0, 3));
      force_ack = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 99) == 0);
      rd = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 99) < 12);
      case ($urandom_range(0, 3))
        0:       tg = 16'h01FE;
        1:       tg = 16'hFFFE;
        default: tg = 16'($urandom);
      endcase
      cycle(r, rd, rv, tg);
      n_checks++;
      if (bus.imem_req !== (!r && !m_halted && !m_full)) begin
        n_fail++; $display("FAIL rand_req n=%0d: got %b want %b", n, bus.imem_req, (!r && !m_halted && !m_full));
      end
      if (bus.imem_req === 1'b1) begin
        n_checks++;
        if (bus.imem_addr !== (m_discard ? m_daddr : m_pc)) begin
          n_fail++; $display("FAIL rand_addr n=%0d: got %h want %h", n, bus.imem_addr, (m_discard ? m_daddr : m_pc));
        end
      end
      n_checks++;
      if ({bus.out_valid, bus.halted} !== {m_full, m_halted}) begin
        n_fail++; $display("FAIL rand_flags n=%0d: valid/halted got %b want %b", n, {bus.out_valid, bus.halted}, {m_full, m_halted});
      end
      n_checks++;
      if ({bus.out_pc, bus.out_insn} !== {m_wpc, m_word}) begin
        n_fail++; $display("FAIL rand_out n=%0d: pc/insn got %h/%h want %h/%h", n, bus.out_pc, bus.out_insn, m_wpc, m_word);
      end
      advance();
    end
    force_ack = 0;
    mem_ovr.delete();
  endtask

  initial begin
    reset               = 1'b1;
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 16'h0;
    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = 16'h0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flight();
    test_redirect_ack();
    test_halt();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
